alu_seq_muldiv: RTL and testbench

//   Parametrised multi-cycle ALU, successor to the combinational ALU. Single-cycle logic/arith ops return in
//   1 clock; unsigned MUL and DIVU run iteratively (1 bit/clock) and return a 2*WIDTH result in Hi/Lo.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_iter_muldiv.sv | 56 +++++
 rtl/alu_seq_muldiv.sv | 154 +++++++++++++++
 tb/tb_alu_seq_muldiv.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map and FSM state encoding for the sequential multiply/divide ALU.
package alu_pkg;

    localparam int unsigned OPW = 4;

    localparam logic [OPW-1:0] ALU_AND  = 4'b0000;
    localparam logic [OPW-1:0] ALU_OR   = 4'b0001;
    localparam logic [OPW-1:0] ALU_ADD  = 4'b0010;
    localparam logic [OPW-1:0] ALU_XOR  = 4'b0011;
    localparam logic [OPW-1:0] ALU_SUB  = 4'b0100;
    localparam logic [OPW-1:0] ALU_MULU = 4'b0101;
    localparam logic [OPW-1:0] ALU_SLTU = 4'b0110;
    localparam logic [OPW-1:0] ALU_SLT  = 4'b0111;
    localparam logic [OPW-1:0] ALU_NOR  = 4'b1000;
    localparam logic [OPW-1:0] ALU_DIVU = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// One-bit-per-clock shift-add multiplier / restoring divider sharing a 2*WIDTH accumulator.
// acc_nxt_c exposes the post-step accumulator so the caller can capture the final result on the last step.
module alu_iter_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic                 div,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   acc_nxt_c
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   op_q;
    logic               div_q;
    logic [WIDTH:0]     psum;
    logic [WIDTH:0]     rs;
    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [2*WIDTH-1:0] div_nxt;

    // acc = {partial/remainder, multiplier/quotient}; A sits in the low half after load
    always_comb begin
        psum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_q} : '0);
        mul_nxt = {psum, acc[WIDTH-1:1]};
        rs      = acc[2*WIDTH-1:WIDTH-1];
        trial   = rs - {1'b0, op_q};
        // remainder stays below the divisor, so trial's top bit is its sign
        div_nxt = trial[WIDTH] ? {rs[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                               : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        acc_nxt_c = acc;
        if (load) begin
            acc_nxt_c = {WIDTH'(0), a};
        end else if (step) begin
            acc_nxt_c = div_q ? div_nxt : mul_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            op_q  <= '0;
            div_q <= 1'b0;
        end else begin
            acc <= acc_nxt_c;
            if (load) begin
                op_q  <= b;
                div_q <= div;
            end
        end
    end

endmodule

// File: rtl/alu_seq_muldiv.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative unsigned MUL/DIVU with
// a Start/Busy/Done handshake; all results and flags are held in output registers.
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Lo,
    output logic [WIDTH-1:0] Hi,
    output logic             Zero,
    output logic             Overflow,
    output logic             DivZero
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic               accept, load, step, wr_single, wr_iter;
    logic [WIDTH-1:0]   sum_c, diff_c;
    logic [WIDTH-1:0]   single_lo, single_hi;
    logic               single_ovf, single_dz;
    logic [2*WIDTH-1:0] acc_nxt_c;

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
        .clk       (CLK),
        .rst       (RST),
        .load      (load),
        .step      (step),
        .div       (ALUControl == ALU_DIVU),
        .a         (SrcA),
        .b         (SrcB),
        .acc_nxt_c (acc_nxt_c)
    );

    // Results of every op that completes in the accept cycle (including DIVU by zero)
    always_comb begin
        sum_c      = SrcA + SrcB;
        diff_c     = SrcA - SrcB;
        single_lo  = '0;
        single_hi  = '0;
        single_ovf = 1'b0;
        single_dz  = 1'b0;
        case (ALUControl)
            ALU_AND:  single_lo = SrcA & SrcB;
            ALU_OR:   single_lo = SrcA | SrcB;
            ALU_XOR:  single_lo = SrcA ^ SrcB;
            ALU_NOR:  single_lo = ~(SrcA | SrcB);
            ALU_ADD: begin
                single_lo  = sum_c;
                single_ovf = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (sum_c[WIDTH-1] != SrcA[WIDTH-1]);
            end
            ALU_SUB: begin
                single_lo  = diff_c;
                single_ovf = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (diff_c[WIDTH-1] != SrcA[WIDTH-1]);
            end
            ALU_SLTU: single_lo = WIDTH'(SrcA < SrcB);
            ALU_SLT:  single_lo = WIDTH'($signed(SrcA) < $signed(SrcB));
            ALU_DIVU: begin
                single_lo = '1;
                single_hi = SrcA;
                single_dz = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        wr_single = 1'b0;
        wr_iter   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    accept = 1'b1;
                    if (ALUControl == ALU_MULU) begin
                        load      = 1'b1;
                        state_nxt = ST_MUL;
                    end else if (ALUControl == ALU_DIVU && SrcB != '0) begin
                        load      = 1'b1;
                        state_nxt = ST_DIV;
                    end else begin
                        wr_single = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                step = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    wr_iter   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST)         cnt <= '0;
        else if (accept) cnt <= '0;
        else if (step)   cnt <= cnt + CW'(1);
    end

    // Busy/Done follow the next state so they line up with the state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Lo       <= '0;
            Hi       <= '0;
            Zero     <= 1'b1;
            Overflow <= 1'b0;
            DivZero  <= 1'b0;
        end else begin
            Busy <= (state_nxt == ST_MUL) || (state_nxt == ST_DIV);
            Done <= (state_nxt == ST_DONE);
            if (accept) begin
                Overflow <= 1'b0;
                DivZero  <= 1'b0;
            end
            if (wr_single) begin
                Lo       <= single_lo;
                Hi       <= single_hi;
                Zero     <= (single_lo == '0);
                Overflow <= single_ovf;
                DivZero  <= single_dz;
            end
            if (wr_iter) begin
                Lo   <= acc_nxt_c[WIDTH-1:0];
                Hi   <= acc_nxt_c[2*WIDTH-1:WIDTH];
                Zero <= (acc_nxt_c[WIDTH-1:0] == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Scoreboard bench for alu_seq_muldiv: 32-bit and 8-bit instances, directed vectors.
module tb_alu_seq_muldiv;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start = 1'b0, start8 = 1'b0;
    logic [3:0]  ctl = '0, ctl8 = '0;
    logic [31:0] a = '0, b = '0;
    logic [7:0]  a8 = '0, b8 = '0;

    logic        busy, done, zero, ovf, dz;
    logic [31:0] lo, hi;
    logic        busy8, done8, zero8, ovf8, dz8;
    logic [7:0]  lo8, hi8;

    alu_seq_muldiv #(.WIDTH(32)) u_dut (
        .CLK(clk), .RST(rst), .Start(start), .ALUControl(ctl), .SrcA(a), .SrcB(b),
        .Busy(busy), .Done(done), .Lo(lo), .Hi(hi), .Zero(zero), .Overflow(ovf), .DivZero(dz)
    );

    alu_seq_muldiv #(.WIDTH(8)) u_dut8 (
        .CLK(clk), .RST(rst), .Start(start8), .ALUControl(ctl8), .SrcA(a8), .SrcB(b8),
        .Busy(busy8), .Done(done8), .Lo(lo8), .Hi(hi8), .Zero(zero8), .Overflow(ovf8), .DivZero(dz8)
    );

    typedef struct {
        string       name;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        z;
        logic        o;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    exp_t e32, e8;

    int n_tests = 0, n_fail = 0;
    int cyc = 0;
    int done_cnt32 = 0, done_cnt8 = 0;
    int busy_cnt32 = 0, busy_cnt8 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic no_exp(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: Done pulse with no operation outstanding (cycle %0d)", name, cyc);
    endtask

    // Monitor: pop and compare on every Done pulse, including its arrival cycle
    always @(negedge clk) begin
        if (busy)  busy_cnt32++;
        if (busy8) busy_cnt8++;
        if (!rst && done) begin
            if (q32.size() == 0) no_exp("dut32");
            else begin
                e32 = q32.pop_front();
                chk({e32.name, " lo"},   64'(lo),   64'(e32.lo));
                chk({e32.name, " hi"},   64'(hi),   64'(e32.hi));
                chk({e32.name, " zero"}, 64'(zero), 64'(e32.z));
                chk({e32.name, " ovf"},  64'(ovf),  64'(e32.o));
                chk({e32.name, " dz"},   64'(dz),   64'(e32.dz));
                chk({e32.name, " done cycle"}, 64'(cyc), 64'(e32.cyc));
            end
            done_cnt32++;
        end
        if (!rst && done8) begin
            if (q8.size() == 0) no_exp("dut8");
            else begin
                e8 = q8.pop_front();
                chk({e8.name, " lo"},   64'(lo8),   64'(e8.lo[7:0]));
                chk({e8.name, " hi"},   64'(hi8),   64'(e8.hi[7:0]));
                chk({e8.name, " zero"}, 64'(zero8), 64'(e8.z));
                chk({e8.name, " ovf"},  64'(ovf8),  64'(e8.o));
                chk({e8.name, " dz"},   64'(dz8),   64'(e8.dz));
                chk({e8.name, " done cycle"}, 64'(cyc), 64'(e8.cyc));
            end
            done_cnt8++;
        end
    end

    task automatic issue(input bit sel, input string name, input logic [3:0] op,
                         input logic [31:0] xa, input logic [31:0] xb,
                         input logic [31:0] elo, input logic [31:0] ehi,
                         input logic ez, input logic eo, input logic edz, input int lat);
        exp_t e;
        @(negedge clk);
        e.name = name; e.lo = elo; e.hi = ehi; e.z = ez; e.o = eo; e.dz = edz;
        e.cyc  = cyc + lat;
        if (sel) begin
            ctl8 = op; a8 = xa[7:0]; b8 = xb[7:0]; start8 = 1'b1;
            q8.push_back(e);
        end else begin
            ctl = op; a = xa; b = xb; start = 1'b1;
            q32.push_back(e);
        end
        @(negedge clk);
        start  = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input string name, input int b0, input int d0, input int exp_busy);
        int k;
        for (k = 0; k < 200; k++) begin
            if ((sel ? done_cnt8 : done_cnt32) != d0) break;
            @(negedge clk);
        end
        if (k == 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no Done within 200 cycles", name);
        end else begin
            chk({name, " busy cycles"}, 64'((sel ? busy_cnt8 : busy_cnt32) - b0), 64'(exp_busy));
        end
    endtask

    task automatic run(input bit sel, input string name, input logic [3:0] op,
                       input logic [31:0] xa, input logic [31:0] xb,
                       input logic [31:0] elo, input logic [31:0] ehi,
                       input logic ez, input logic eo, input logic edz, input int lat);
        int b0, d0;
        b0 = sel ? busy_cnt8 : busy_cnt32;
        d0 = sel ? done_cnt8 : done_cnt32;
        issue(sel, name, op, xa, xb, elo, ehi, ez, eo, edz, lat);
        wait_done(sel, name, b0, d0, (lat > 1) ? lat - 1 : 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " lo"},   64'(lo),    64'h0);
        chk({tag, " hi"},   64'(hi),    64'h0);
        chk({tag, " zero"}, 64'(zero),  64'h1);
        chk({tag, " ovf"},  64'(ovf),   64'h0);
        chk({tag, " dz"},   64'(dz),    64'h0);
        chk({tag, " busy"}, 64'(busy),  64'h0);
        chk({tag, " done"}, 64'(done),  64'h0);
        chk({tag, " lo8"},  64'(lo8),   64'h0);
    endtask

    initial begin
        int b0, d0;
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;

        // single-cycle ops
        run(0, "add_ovf",  ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b0, 1'b1, 1'b0, 1);
        run(0, "add_wrap", ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1);
        run(0, "sub_ovf",  ALU_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b0, 1'b1, 1'b0, 1);
        run(0, "and",      ALU_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0, 1'b0, 1'b0, 1'b0, 1);
        run(0, "or",       ALU_OR,   32'h12340000, 32'h00005678, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b0, 1);
        run(0, "xor",      ALU_XOR,  32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 32'h0, 1'b0, 1'b0, 1'b0, 1);
        run(0, "nor",      ALU_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1);
        run(0, "slt",      ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0, 1'b0, 1);
        run(0, "sltu",     ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1);
        run(0, "op1111",   4'b1111,  32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'h0, 1'b1, 1'b0, 1'b0, 1);

        // iterative ops and divide by zero
        run(0, "mulu_max", ALU_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 33);
        run(0, "mulu_sh",  ALU_MULU, 32'h12345678, 32'h00000010, 32'h23456780, 32'h00000001, 1'b0, 1'b0, 1'b0, 33);
        run(0, "mulu_0",   ALU_MULU, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 33);
        run(0, "divu_100", ALU_DIVU, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 1'b0, 33);
        run(0, "divu_big", ALU_DIVU, 32'hFFFFFFFF, 32'h00000010, 32'h0FFFFFFF, 32'h0000000F, 1'b0, 1'b0, 1'b0, 33);
        run(0, "divu_lt",  ALU_DIVU, 32'd3,        32'd7,        32'd0,        32'd3,        1'b1, 1'b0, 1'b0, 33);
        run(0, "divu_0",   ALU_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b0, 1'b0, 1'b1, 1);
        run(0, "dz_clr",   ALU_ADD,  32'd1,        32'd1,        32'd2,        32'd0,        1'b0, 1'b0, 1'b0, 1);

        // Start during Busy is ignored; operand changes mid-iteration have no effect
        b0 = busy_cnt32; d0 = done_cnt32;
        issue(0, "mul_ign", ALU_MULU, 32'd3, 32'd5, 32'd15, 32'd0, 1'b0, 1'b0, 1'b0, 33);
        repeat (3) @(negedge clk);
        ctl = ALU_ADD; a = 32'h7FFFFFFF; b = 32'hDEADBEEF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(0, "mul_ign", b0, d0, 32);

        // Reset mid-iteration discards the op with no Done pulse
        issue(0, "mul_rst", ALU_MULU, 32'd7, 32'd9, 32'd63, 32'd0, 1'b0, 1'b0, 1'b0, 33);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        q32.delete();
        @(negedge clk);
        chk_reset("mid_rst");
        rst = 1'b0;
        d0 = done_cnt32;
        repeat (40) @(negedge clk);
        chk("no done after reset", 64'(done_cnt32 - d0), 64'h0);
        run(0, "add_post", ALU_ADD, 32'd2, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 1);
        run(0, "mul_post", ALU_MULU, 32'd7, 32'd9, 32'd63, 32'd0, 1'b0, 1'b0, 1'b0, 33);

        // WIDTH=8 instance
        run(1, "w8_mulu",  ALU_MULU, 32'hFF, 32'hFF, 32'h01, 32'hFE, 1'b0, 1'b0, 1'b0, 9);
        run(1, "w8_divu",  ALU_DIVU, 32'hC8, 32'h0D, 32'h0F, 32'h05, 1'b0, 1'b0, 1'b0, 9);
        run(1, "w8_add",   ALU_ADD,  32'h7F, 32'h01, 32'h80, 32'h00, 1'b0, 1'b1, 1'b0, 1);
        run(1, "w8_div0",  ALU_DIVU, 32'h80, 32'h00, 32'hFF, 32'h80, 1'b0, 1'b0, 1'b1, 1);
        run(1, "w8_mul0",  ALU_MULU, 32'h10, 32'h10, 32'h00, 32'h01, 1'b1, 1'b0, 1'b0, 9);

        repeat (3) @(negedge clk);
        chk("queue32 drained", 64'(q32.size()), 64'h0);
        chk("queue8 drained",  64'(q8.size()),  64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
